// File: rtl/up_down_counter_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the up/down counter controller.
package up_down_counter_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DN   = 2'b11;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    typedef struct packed {
        logic       rst;
        logic       up;
        logic       dn;
    } strobe_t;

    function automatic strobe_t op_strobe(input logic [1:0] op);
        strobe_t s;
        s.rst = (op == OP_LOAD);
        s.up  = (op == OP_UP);
        s.dn  = (op == OP_DN);
        return s;
    endfunction

endpackage

// File: rtl/up_down_counter_ctrl_arb.sv
// Two-way round-robin arbiter; pointer moves past the winner on accept.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // ptr == 0 favours requester 0 when both are valid
    logic ptr;

    assign grant0 = valid0 && (!valid1 || !ptr);
    assign grant1 = valid1 && (!valid0 || ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= grant0;
        end
    end

endmodule

// File: rtl/up_down_counter_ctrl.sv
// Round-robin command controller driving one up/down counter and
// checking its result against a predicted value.
module up_down_counter_ctrl
    import up_down_counter_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic [W-1:0] ctr_a,
    output logic [W-1:0] ctr_b,
    output logic         ctr_rst,
    output logic         ctr_up,
    output logic         ctr_dn,
    input  logic [W-1:0] ctr_q,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_q,
    output logic         rsp_sat,
    output logic         busy,
    output logic         err
);

    logic [1:0]   state;
    logic [1:0]   op_r;
    logic [W-1:0] data_r;
    logic [W-1:0] qb_r;
    logic         id_r;

    logic         grant0;
    logic         grant1;
    logic         idle;
    logic         acc0;
    logic         acc1;
    logic         accept;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         sat;
    logic [W-1:0] expect_q;
    strobe_t      stb;

    assign idle   = (state == S_IDLE);
    assign acc0   = idle && req0_valid && grant0;
    assign acc1   = idle && req1_valid && grant1;
    assign accept = acc0 || acc1;

    assign req0_ready = idle && grant0;
    assign req1_ready = idle && grant1;
    assign busy       = !idle;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Operand register doubles as the counter a/b bus, so it holds between ops
    assign ctr_a = data_r;
    assign ctr_b = data_r;

    // Strobes decode from state, so an async reset drops them at once
    assign stb     = op_strobe(op_r);
    assign ctr_rst = (state == S_ISSUE) && stb.rst;
    assign ctr_up  = (state == S_ISSUE) && stb.up;
    assign ctr_dn  = (state == S_ISSUE) && stb.dn;

    // Carry/borrow out of the W+1 bit result is the overflow guard verdict
    assign sum  = {1'b0, qb_r} + {1'b0, data_r};
    assign diff = {1'b0, qb_r} - {1'b0, data_r};

    always_comb begin
        sat      = 1'b0;
        expect_q = qb_r;
        case (op_r)
            OP_LOAD: expect_q = data_r;
            OP_UP: begin
                sat = sum[W];
                if (!sum[W]) begin
                    expect_q = sum[W-1:0];
                end
            end
            OP_DN: begin
                sat = diff[W];
                if (!diff[W]) begin
                    expect_q = diff[W-1:0];
                end
            end
            default: expect_q = qb_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_r      <= OP_NOP;
            data_r    <= '0;
            qb_r      <= '0;
            id_r      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_q     <= '0;
            rsp_sat   <= 1'b0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= acc1 ? req1_op : req0_op;
                        data_r <= acc1 ? req1_data : req0_data;
                        id_r   <= acc1;
                        qb_r   <= ctr_q;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_r;
                    rsp_q     <= ctr_q;
                    rsp_sat   <= sat;
                    if (ctr_q != expect_q) begin
                        err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/up_down_counter_ctrl.md
Name: up_down_counter_ctrl

Overview:
- Two-requester command controller for the 8-bit up/down counter datapath.
- Arbitrates round-robin between two command ports and issues one LOAD/UP/DN/NOP per grant as single-cycle strobes on the counter control pins.
- Captures the resulting counter value and reports it with a saturation ("refused by overflow guard") flag.
- Sits between software-facing command sources and one up/down counter instance; it owns that counter's control inputs exclusively.

Parameters:
- W, 8, data width of the counter value and operands; must match the controlled counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 command valid
- req0_op  in  2  requester 0 opcode: 00 NOP, 01 LOAD, 10 UP, 11 DN
- req0_data  in  W  requester 0 operand
- req0_ready  out  1  requester 0 accept
- req1_valid  in  1  requester 1 command valid
- req1_op  in  2  requester 1 opcode, same encoding
- req1_data  in  W  requester 1 operand
- req1_ready  out  1  requester 1 accept
- ctr_a  out  W  counter load value
- ctr_b  out  W  counter step value
- ctr_rst  out  1  counter load strobe; the counter's synchronous load-from-a
- ctr_up  out  1  counter up strobe
- ctr_dn  out  1  counter down strobe
- ctr_q  in  W  counter current value
- rsp_valid  out  1  response pulse
- rsp_id  out  1  requester index of the response
- rsp_q  out  W  counter value after the op
- rsp_sat  out  1  op refused by the counter's overflow/underflow guard
- busy  out  1  controller not in IDLE
- err  out  1  sticky: counter result disagreed with prediction

Behaviour:
- Reset (async, immediate):
  - State IDLE; RR pointer favours req0.
  - All outputs 0 except that ready follows the IDLE rule.
  - err cleared.
  - No command is issued to the counter; counter contents are untouched.
- FSM: IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, the grant goes to the pointer.
  - reqN_ready = (state==IDLE) && grantN. This is combinational, and at most one ready is high.
  - Accept = valid && ready at the clock edge.
  - On accept, latch op, data, id, and q_before = ctr_q. The pointer moves to the non-granted requester. Go to ISSUE.
- ISSUE (exactly one cycle):
  - ctr_a = ctr_b = latched data.
  - Assert exactly one of ctr_rst (LOAD), ctr_up (UP), ctr_dn (DN). Assert none for NOP.
  - The counter updates on the edge ending ISSUE.
- CAPTURE:
  - Register rsp_q = ctr_q, rsp_id, and rsp_sat.
  - rsp_sat rules:
    - UP: data > (2^W-1) - q_before
    - DN: data > q_before
    - LOAD and NOP: 0
  - Expected value:
    - sat: q_before
    - LOAD: data
    - UP: q_before+data
    - DN: q_before-data
    - NOP: q_before
  - If ctr_q differs from the expected value, set err.
  - Go to IDLE.
- Response: rsp_valid is a one-cycle pulse in the cycle after CAPTURE. rsp_q, rsp_id and rsp_sat hold until the next response.
- Latency: accept edge T; strobe during T+1; rsp_valid during T+3. Next accept is possible at the T+3 edge, giving 1 op per 3 cycles.
- ctr_a/ctr_b retain their last values outside ISSUE. Strobes are 0 outside ISSUE.
- Width rules: sat comparisons are unsigned W-bit. Expected-value sums are computed in W+1 bits and truncated only when not saturated.
- Boundaries:
  - UP with data 0: not sat, q unchanged.
  - UP reaching exactly 2^W-1: not sat.
  - DN reaching exactly 0: not sat.
  - LOAD is never sat.
- Requester protocol: hold valid/op/data stable until accepted. Dropping valid before accept is allowed; the request is then simply lost.
- Reset mid-operation: strobes drop asynchronously and the in-flight op gets no response. If reset asserts during ISSUE, the counter may or may not apply the op depending on edge timing; the system treats counter contents as unknown after a controller reset until a LOAD.
- err is sticky until rst.

Decomposition:
- Package up_down_counter_ctrl_pkg:
  - opcode localparams OP_NOP/OP_LOAD/OP_UP/OP_DN
  - state encoding S_IDLE/S_ISSUE/S_CAPTURE
- One sub-module, rr_arb2: 2-way round-robin arbiter with valid inputs, grant outputs and an update-on-accept pointer.

Test Plan:
- After reset, req0 LOAD 0x10 -> req0_ready high; ctr_rst=1, ctr_a=0x10 for one cycle at T+1; rsp_valid at T+3 with id 0, q 0x10, sat 0.
- q=0xF0, req1 UP 0x20 -> rsp_sat=1, rsp_q=0xF0. Then UP 0x0F -> rsp_q=0xFF, sat 0. Then UP 0x00 -> q 0xFF, sat 0.
- q=0x05, DN 0x06 -> sat 1, q 0x05. Then DN 0x05 -> q 0x00, sat 0.
- Both requesters continuously valid with UP 0x01 from q=0 -> grants alternate 0,1,0,1 starting at 0; rsp_id alternates; q increments 1 per 3 cycles; never both ready high.
- rst asserted mid-ISSUE -> ctr_up drops without waiting for a clock edge; no rsp_valid; after release, req0 wins a simultaneous request.
- Bench counter model ignores a non-saturating UP 0x03 at q=0x10 (q stays 0x10) -> err=1 from the cycle after CAPTURE, held through later ops until rst.
